// File: rtl/clint_mhart.sv
// Multi-hart core-local interruptor: one shared 64-bit mtime, a per-hart mtimecmp and msip,
// and registered bus reads/acks plus registered timer/software interrupt outputs.
module clint_mhart #(
  parameter int NHARTS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_addr,
  input  logic [3:0]        i_we,
  input  logic [31:0]       i_dat_w,
  input  logic              i_stb,
  output logic [31:0]       o_dat_r,
  output logic              o_ack,
  output logic [NHARTS-1:0] o_timer_int,
  output logic [NHARTS-1:0] o_software_int
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;

  logic [15:0]       pre_cnt;
  logic              tick;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp [NHARTS];
  logic [NHARTS-1:0] msip;

  logic        accept;
  logic        wr;
  logic        in_msip;
  logic        in_cmp;
  logic        sel_mtlo;
  logic        sel_mthi;
  logic [11:0] msip_idx;
  logic [10:0] cmp_idx;
  logic        cmp_hi;
  logic [31:0] rdata;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  assign accept   = i_stb && !o_ack;
  assign wr       = accept && (i_we != 4'b0000);
  assign tick     = (pre_cnt == PRESCALE_LAST);
  assign in_msip  = (i_addr[15:14] == 2'b00) && (i_addr[1:0] == 2'b00);
  assign in_cmp   = (i_addr[15:14] == 2'b01) && (i_addr[1:0] == 2'b00);
  assign sel_mtlo = (i_addr == MTIME_LO);
  assign sel_mthi = (i_addr == MTIME_HI);
  assign msip_idx = i_addr[13:2];
  assign cmp_idx  = i_addr[13:3];
  assign cmp_hi   = i_addr[2];

  // Harts at or beyond NHARTS never match an index, so their slots read 0 and ignore writes.
  always_comb begin
    rdata = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (in_msip && msip_idx == 12'(h))
        rdata = {31'b0, msip[h]};
      if (in_cmp && cmp_idx == 11'(h))
        rdata = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
    if (sel_mtlo) rdata = mtime[31:0];
    if (sel_mthi) rdata = mtime[63:32];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ack   <= 1'b0;
      o_dat_r <= '0;
    end else begin
      o_ack   <= accept;
      o_dat_r <= accept ? rdata : '0;
    end
  end

  // A bus write to mtime wins over a coincident tick and restarts the prescaler.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime   <= '0;
      pre_cnt <= '0;
    end else if (wr && sel_mtlo) begin
      mtime[31:0] <= merge(mtime[31:0], i_dat_w, i_we);
      pre_cnt     <= '0;
    end else if (wr && sel_mthi) begin
      mtime[63:32] <= merge(mtime[63:32], i_dat_w, i_we);
      pre_cnt      <= '0;
    end else if (tick) begin
      mtime   <= mtime + 64'd1;
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      msip           <= '0;
      o_timer_int    <= '0;
      o_software_int <= '0;
      for (int h = 0; h < NHARTS; h++)
        mtimecmp[h] <= '1;
    end else begin
      o_software_int <= msip;
      for (int h = 0; h < NHARTS; h++) begin
        o_timer_int[h] <= (mtime >= mtimecmp[h]);
        if (wr && in_msip && msip_idx == 12'(h) && i_we[0])
          msip[h] <= i_dat_w[0];
        if (wr && in_cmp && cmp_idx == 11'(h)) begin
          if (cmp_hi)
            mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], i_dat_w, i_we);
          else
            mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], i_dat_w, i_we);
        end
      end
    end
  end

endmodule
